// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and hands
// words to decode over valid/ready, redirecting on j and taken beq.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    output logic [31:0] fetch_count
);

    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  boot_cnt;
    logic [31:0] pc;
    logic        running;
    logic        take;
    logic        load;
    logic        redirect;
    logic [31:0] seq;
    logic [31:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == BOOT && boot_cnt == BOOT_LAST)
            state_nxt = RUN;
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             boot_cnt <= '0;
        else if (state == BOOT) boot_cnt <= boot_cnt + 4'd1;
    end

    assign take     = valid_out & ready_in;
    assign load     = en & (~valid_out | ready_in);
    assign redirect = take & (jmp | br_taken);
    assign seq      = pc_out + 32'd1;
    // jmp has priority over br_taken when both are raised
    assign target   = jmp ? {seq[31:26], jmp_index}
                          : seq + {{16{br_offset[15]}}, br_offset};
    assign rom_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_out   <= '0;
            pc_out      <= '0;
            valid_out   <= 1'b0;
            fetch_count <= '0;
        end else if (running) begin
            if (take)
                fetch_count <= fetch_count + 32'd1;
            // A redirect squashes the sequential word at pc; the target is fetched next cycle
            if (redirect) begin
                pc        <= target;
                valid_out <= 1'b0;
            end else if (load) begin
                instr_out <= rom_data;
                pc_out    <= pc;
                valid_out <= 1'b1;
                pc        <= pc + 32'd1;
            end else if (take) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected fetch PCs,
// backpressure, jump/branch redirects with bubbles, and async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;
    logic        jmp;
    logic [25:0] jmp_index;
    logic        br_taken;
    logic [15:0] br_offset;
    logic [31:0] fetch_count;

    logic [31:0] rom [16];
    logic [31:0] sb [$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[3:0]];

    instr_fetch #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out), .ready_in(ready_in),
        .jmp(jmp), .jmp_index(jmp_index), .br_taken(br_taken), .br_offset(br_offset),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decode behaviour for the k-th take of a phase; nxt is the next PC decode should see.
    task automatic redir(input int phase, input int k, input logic [31:0] p,
                         output logic r, output logic j, output logic [25:0] idx,
                         output logic b, output logic [15:0] off, output logic [31:0] nxt);
        r = 1'b1; j = 1'b0; idx = '0; b = 1'b0; off = '0; nxt = p + 32'd1;
        if (phase == 1 && k == 6)       begin b = 1'b1; off = 16'hFFFA; nxt = 32'd0; end
        else if (phase == 1 && k == 8)  begin b = 1'b1; off = 16'h0001; nxt = 32'd3; end
        else if (phase == 1 && k == 9)  begin j = 1'b1; idx = 26'd0;    nxt = 32'd0; end
        else if (phase == 1 && k == 10) begin j = 1'b1; idx = 26'd4;    nxt = 32'd4; end
        else if (phase == 1 && k == 12) begin b = 1'b1; off = 16'hFFFC; nxt = 32'd2; end
        else if (phase == 1 && k == 13) begin
            j = 1'b1; idx = 26'd7; b = 1'b1; off = 16'h0001; nxt = 32'd7;
        end
        else r = 1'b0;
    endtask

    task automatic run_phase(input int phase, input int ntakes, input int budget);
        int          takes = 0;
        int          stall = 0;
        bit          stall_done = 0;
        bit          prev_redir = 0;
        bit          prev_seq = 0;
        logic        r;
        logic [31:0] p;
        logic [31:0] nxt;
        sb.push_back(32'd0);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            chk("fetch_count", fetch_count, exp_cnt);
            if (prev_redir) chk("bubble", {31'd0, valid_out}, 32'd0);
            if (prev_seq)   chk("no_bubble", {31'd0, valid_out}, 32'd1);
            prev_redir = 0;
            prev_seq   = 0;
            if (takes == ntakes) break;
            if (phase == 1 && !stall_done && valid_out && takes == 1) begin
                stall = 3;
                stall_done = 1;
            end
            if (stall > 0) begin
                ready_in = 1'b0;
                chk("stall_pc_out", pc_out, 32'd1);
                chk("stall_instr", instr_out, rom[1]);
                chk("stall_pc", rom_addr, 32'd2);
                stall--;
            end else begin
                ready_in = 1'b1;
            end
            jmp = 1'b0; jmp_index = '0; br_taken = 1'b0; br_offset = '0;
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                    p = pc_out;
                end else begin
                    p = sb.pop_front();
                    chk("pc_out", pc_out, p);
                    chk("instr_out", instr_out, rom[p[3:0]]);
                end
                takes++;
                redir(phase, takes, p, r, jmp, jmp_index, br_taken, br_offset, nxt);
                sb.push_back(nxt);
                exp_cnt = exp_cnt + 32'd1;
                prev_redir = r;
                prev_seq   = !r;
            end
        end
        jmp = 1'b0; br_taken = 1'b0;
        chk("take_budget", takes, ntakes);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0013);
        rst_n = 1'b0; en = 1'b1; ready_in = 1'b1;
        jmp = 1'b0; jmp_index = '0; br_taken = 1'b0; br_offset = '0;
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", rom_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_valid", {31'd0, valid_out}, 32'd0);
        run_phase(1, 15, 200);

        chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_instr", instr_out, 32'd0);
        chk("arst_pc_out", pc_out, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_addr", rom_addr, 32'd0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reboot_valid", {31'd0, valid_out}, 32'd0);
        run_phase(2, 3, 50);
        chk("final_count", fetch_count, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
